switch_input_pio: RTL and testbench



---
 rtl/switch_input_pio_pkg.sv | 13 +
 rtl/switch_input_pio_debounce_bit.sv | 48 ++++
 rtl/switch_input_pio.sv | 99 +++++++++
 tb/tb_switch_input_pio.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/switch_input_pio_pkg.sv
// rtl/switch_input_pio_pkg.sv - register offsets and edge-mode encodings for the switch input port
package switch_input_pio_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_RAW     = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/switch_input_pio_debounce_bit.sv
// rtl/switch_input_pio_debounce_bit.sv - one-bit synchroniser plus saturating-free debounce counter
module debounce_bit #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic pin,
   output logic sync,
   output logic stable
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt;
   logic                   stable_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];

   // The counter only runs while sync disagrees with stable, and is cleared on
   // acceptance, so it can never pass CNT_LAST.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt      <= '0;
         stable_q <= 1'b0;
      end else if (sync == stable_q) begin
         cnt <= '0;
      end else if (cnt == CNT_LAST) begin
         stable_q <= sync;
         cnt      <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign stable = stable_q;

endmodule

// File: rtl/switch_input_pio.sv
// rtl/switch_input_pio.sv - Avalon-MM switch/button input port with debounce, edge capture and irq
module switch_input_pio
   import switch_input_pio_pkg::*;
#(
   parameter int WIDTH           = 18,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int EDGE_MODE       = EDGE_RISE
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             read,
   input  logic             write,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   logic [WIDTH-1:0] raw;
   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] stable_d;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] irqmask;
   logic [WIDTH-1:0] edgecap;
   logic [31:0]      rd_next;
   logic             wr_en;
   logic             unused_bits;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk    (clk),
         .reset  (reset),
         .pin    (in_port[i]),
         .sync   (raw[i]),
         .stable (stable[i])
      );
   end

   always_comb begin
      edge_det = stable & ~stable_d;
      case (EDGE_MODE)
         EDGE_FALL: edge_det = ~stable & stable_d;
         EDGE_ANY:  edge_det = stable ^ stable_d;
         default:   edge_det = stable & ~stable_d;
      endcase
   end

   assign wr_en = chipselect & write;

   // Clear-by-write is applied before the OR so a simultaneous new edge wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stable_d <= '0;
         irqmask  <= '0;
         edgecap  <= '0;
      end else begin
         stable_d <= stable;
         if (wr_en && address == ADDR_IRQMASK) begin
            irqmask <= writedata[WIDTH-1:0];
         end
         if (wr_en && address == ADDR_EDGECAP) begin
            edgecap <= (edgecap & ~writedata[WIDTH-1:0]) | edge_det;
         end else begin
            edgecap <= edgecap | edge_det;
         end
      end
   end

   always_comb begin
      rd_next = '0;
      case (address)
         ADDR_DATA:    rd_next[WIDTH-1:0] = stable;
         ADDR_RAW:     rd_next[WIDTH-1:0] = raw;
         ADDR_IRQMASK: rd_next[WIDTH-1:0] = irqmask;
         ADDR_EDGECAP: rd_next[WIDTH-1:0] = edgecap;
         default:      rd_next = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         readdata <= '0;
      end else begin
         readdata <= rd_next;
      end
   end

   assign irq = |(edgecap & irqmask);

   // read is part of the bus interface but readdata refreshes every cycle.
   assign unused_bits = &{1'b0, read, writedata};

endmodule

// File: tb/tb_switch_input_pio.sv
// tb/tb_switch_input_pio.sv - directed vector bench for switch_input_pio (debounce 4, widths 18 and 4)
module tb_switch_input_pio;
   import switch_input_pio_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [17:0] pins_a;
   logic [3:0]  pins_4;
   logic [31:0] rd_a, rd_b, rd_c;
   logic        irq_a, irq_b, irq_c;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   switch_input_pio #(.WIDTH(18), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(EDGE_RISE)) dut_a (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .read(read),
      .write(write), .writedata(writedata), .readdata(rd_a), .in_port(pins_a), .irq(irq_a)
   );

   switch_input_pio #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(EDGE_FALL)) dut_b (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .read(read),
      .write(write), .writedata(writedata), .readdata(rd_b), .in_port(pins_4), .irq(irq_b)
   );

   switch_input_pio #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_MODE(EDGE_ANY)) dut_c (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .read(read),
      .write(write), .writedata(writedata), .readdata(rd_c), .in_port(pins_4), .irq(irq_c)
   );

   typedef struct {
      string       name;
      logic [17:0] pins;
      logic [1:0]  addr;
      logic        wr;
      logic        cs;
      logic [31:0] wdata;
      int          ticks;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } step_t;

   step_t vec[$];

   function automatic void add(input string n, input logic [17:0] p, input logic [1:0] a,
                               input logic wr, input logic cs, input logic [31:0] wd,
                               input int t, input logic [31:0] er, input logic ei);
      step_t s;
      s.name = n; s.pins = p; s.addr = a; s.wr = wr; s.cs = cs;
      s.wdata = wd; s.ticks = t; s.exp_rd = er; s.exp_irq = ei;
      vec.push_back(s);
   endfunction

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, got, exp);
      end
   endtask

   task automatic check1(input string name, input logic got, input logic exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b, required %b", name, got, exp);
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write      = 1'b1;
      tick(1);
      write      = 1'b0;
   endtask

   initial begin
      //  name            pins      a  wr cs wdata      t   rd        irq
      add("idle",         18'h0,    0, 0, 1, 32'h0,     2,  32'h0,    0);
      add("glitch_hi",    18'h1,    0, 0, 1, 32'h0,     3,  32'h0,    0);
      add("glitch_lo",    18'h0,    0, 0, 1, 32'h0,     8,  32'h0,    0);
      add("hold_pre",     18'h1,    0, 0, 1, 32'h0,     6,  32'h0,    0);
      add("hold_acc",     18'h1,    0, 0, 1, 32'h0,     1,  32'h1,    0);
      add("ec_read",      18'h1,    3, 0, 1, 32'h0,     1,  32'h1,    0);
      add("mask_wr",      18'h1,    2, 1, 1, 32'h1,     1,  32'h0,    1);
      add("mask_rd",      18'h1,    2, 0, 1, 32'h0,     1,  32'h1,    1);
      add("mask_nocs",    18'h1,    2, 1, 0, 32'h0,     2,  32'h1,    1);
      add("fall_nocap",   18'h0,    3, 0, 1, 32'h0,     10, 32'h1,    1);
      add("ec_clr",       18'h0,    3, 1, 1, 32'h1,     1,  32'h1,    0);
      add("ec_rd0",       18'h0,    3, 0, 1, 32'h0,     1,  32'h0,    0);
      add("mask_edge",    18'h20,   3, 0, 1, 32'h0,     8,  32'h20,   0);
      add("mask_wr20",    18'h20,   2, 1, 1, 32'h20,    1,  32'h1,    1);
      add("raw_rd",       18'h20,   1, 0, 1, 32'h0,     1,  32'h20,   1);
      add("data_wr_ign",  18'h20,   0, 1, 1, 32'h3ffff, 1,  32'h20,   1);
      add("ec_clr5",      18'h20,   3, 1, 1, 32'h20,    1,  32'h20,   0);
      add("raw_lead",     18'h21,   1, 0, 1, 32'h0,     3,  32'h21,   0);
      add("data_lag",     18'h21,   0, 0, 1, 32'h0,     1,  32'h20,   0);
      add("data_acc",     18'h21,   0, 0, 1, 32'h0,     3,  32'h21,   0);

      reset = 1'b1; address = '0; chipselect = 1'b1; read = 1'b1; write = 1'b0;
      writedata = '0; pins_a = '0; pins_4 = '0;
      tick(3);
      check32("reset_rd", rd_a, 32'h0);
      check1("reset_irq", irq_a, 1'b0);
      reset = 1'b0;

      foreach (vec[i]) begin
         pins_a     = vec[i].pins;
         address    = vec[i].addr;
         writedata  = vec[i].wdata;
         chipselect = vec[i].cs;
         write      = vec[i].wr;
         tick(1);
         write      = 1'b0;
         chipselect = 1'b1;
         if (vec[i].ticks > 1) tick(vec[i].ticks - 1);
         check32({vec[i].name, "_rd"}, rd_a, vec[i].exp_rd);
         check1({vec[i].name, "_irq"}, irq_a, vec[i].exp_irq);
      end

      // Clear request lands on the same edge that captures a new rising edge.
      bus_write(ADDR_IRQMASK, 32'h21);
      check1("sim_mask_irq", irq_a, 1'b1);
      pins_a = 18'h20;
      tick(8);
      pins_a = 18'h21;
      tick(6);
      bus_write(ADDR_EDGECAP, 32'h1);
      check1("sim_irq", irq_a, 1'b1);
      address = ADDR_EDGECAP;
      tick(1);
      check32("sim_ec", rd_a, 32'h1);

      // Reset mid-run with pending edges and mask set, pins held high across release.
      bus_write(ADDR_IRQMASK, 32'h3);
      pins_a = 18'h23;
      tick(8);
      address = ADDR_EDGECAP;
      tick(1);
      check32("pre_rst_ec", rd_a, 32'h3);
      check1("pre_rst_irq", irq_a, 1'b1);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check32("rst_async_rd", rd_a, 32'h0);
      check1("rst_async_irq", irq_a, 1'b0);
      tick(2);
      check32("rst_hold_rd", rd_a, 32'h0);
      reset   = 1'b0;
      address = ADDR_DATA;
      tick(6);
      check32("rel_data_early", rd_a, 32'h0);
      tick(1);
      check32("rel_data", rd_a, 32'h23);
      address = ADDR_EDGECAP;
      tick(1);
      check32("rel_ec", rd_a, 32'h23);
      check1("rel_irq", irq_a, 1'b0);
      address = ADDR_IRQMASK;
      tick(1);
      check32("rel_mask", rd_a, 32'h0);

      // Falling-only and any-edge instances, one pulse on bit 3.
      address = ADDR_EDGECAP;
      pins_4  = 4'h8;
      tick(8);
      check32("fall_after_rise", rd_b, 32'h0);
      check32("any_after_rise", rd_c, 32'h8);
      bus_write(ADDR_EDGECAP, 32'hffffffff);
      pins_4 = 4'h0;
      tick(8);
      check32("fall_after_fall", rd_b, 32'h8);
      check32("any_after_fall", rd_c, 32'h8);

      bus_write(ADDR_IRQMASK, 32'hffffffff);
      check1("fall_irq", irq_b, 1'b1);
      check1("any_irq", irq_c, 1'b1);
      for (int a = 0; a < 4; a++) begin
         address = 2'(a);
         tick(1);
         check32($sformatf("b_hi_a%0d", a), rd_b & 32'hfffffff0, 32'h0);
         check32($sformatf("c_hi_a%0d", a), rd_c & 32'hfffffff0, 32'h0);
         if (a == 2) begin
            check32("b_mask_full", rd_b, 32'hf);
            check32("a_mask_full", rd_a, 32'h3ffff);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
